// File: rtl/fetch_pkg.sv
// Shared fetch-side definitions: field width defaults, reset PC and the
// {pc, instr} entry type used by the queue and the decode-side register.
package fetch_pkg;

  localparam int PC_W_DEF    = 32;
  localparam int INSTR_W_DEF = 32;

  localparam logic [PC_W_DEF-1:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [PC_W_DEF-1:0]    pc;
    logic [INSTR_W_DEF-1:0] instr;
  } fd_entry_t;

endpackage

// File: rtl/fd_queue_storage.sv
// Register array for the fetch/decode queue: one write port, one
// asynchronous read port, cleared to zero by the synchronous reset.
module fd_queue_storage
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = PC_W_DEF + INSTR_W_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Entry storage: clear on reset, otherwise write the pushed entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode buffer holding up to DEPTH {pc, instr} pairs with
// valid/ready on both sides and a flush for fetch redirects.
module fetch_decode_queue
  import fetch_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [CNT_W-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = PC_W + INSTR_W;

  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_s;
  logic             pop_s;
  logic [EW-1:0]    rdata_s;

  // in_ready depends on occupancy alone, so a full queue never refills in the cycle it pops.
  assign in_ready  = (count_r != CNT_W'(DEPTH));
  assign out_valid = (count_r != {CNT_W{1'b0}});
  assign push_s    = in_valid & in_ready & ~flush;
  assign pop_s     = out_valid & out_ready & ~flush;

  // Pointer and occupancy update; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  fd_queue_storage #(
    .DEPTH (DEPTH),
    .WIDTH (EW),
    .AW    (AW)
  ) u_storage (
    .clk   (clk),
    .rst   (rst),
    .we    (push_s),
    .waddr (wr_ptr_r),
    .wdata ({in_pc, in_instr}),
    .raddr (rd_ptr_r),
    .rdata (rdata_s)
  );

  assign out_pc    = rdata_s[EW-1:INSTR_W];
  assign out_instr = rdata_s[INSTR_W-1:0];
  assign count     = count_r;

endmodule

// File: doc/fetch_decode_queue.md
# fetch_decode_queue

Parametrised fetch-to-decode buffer: the next generation of the single-entry fetch output register. It holds up to DEPTH fetched {pc, instr} pairs between the fetch and decode stages, using a valid/ready handshake on both sides. A flush input discards all queued entries when a branch, jump or trap redirects fetch. Outputs come straight from flops, so there is no combinational path from input to output.

## Interface
- PC_W, 32, width of the program-counter field
- INSTR_W, 32, width of the instruction field
- DEPTH, 4, number of entries; must be a power of two and at least 2
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all entries this cycle (redirect from execute or trap)
- in_valid  in  1  fetch offers in_pc/in_instr
- in_ready  out  1  queue can accept an entry; equals (count != DEPTH)
- in_pc  in  PC_W  fetched PC
- in_instr  in  INSTR_W  fetched instruction word
- out_valid  out  1  head entry is valid; equals (count != 0)
- out_ready  in  1  decode takes the head entry
- out_pc  out  PC_W  PC of the head entry
- out_instr  out  INSTR_W  instruction of the head entry
- count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH

## Operation
- push = in_valid & in_ready & ~flush
- pop = out_valid & out_ready & ~flush
- Storage is a circular array with wr_ptr and rd_ptr, each log2(DEPTH) bits. Pointers wrap modulo DEPTH with no special-casing.
- Push: write mem[wr_ptr] and increment wr_ptr.
- Pop: increment rd_ptr.
- count update: +1 on push only, -1 on pop only, unchanged on push+pop or on neither.
- Push and pop in the same cycle are legal whenever 0 < count < DEPTH.
- When count == 0, a push cannot be popped in the same cycle. There is no bypass.
- When count == DEPTH, in_ready = 0 regardless of out_ready. A same-cycle pop-and-refill is not allowed when full, so in_ready depends only on count, never on out_ready.
- out_pc and out_instr = mem[rd_ptr]. Their value is undefined-but-stable when out_valid = 0; the bench must not check them then.
- Flush:
  - Next cycle: rd_ptr = wr_ptr = 0 and count = 0.
  - Any push or pop offered in the flush cycle is dropped.
  - Storage contents are not cleared.
- Reset:
  - Same effect as flush, plus every mem entry is set to 0.
  - Output values during and after reset: out_valid = 0, out_pc = 0, out_instr = 0, count = 0, in_ready = 1.
- Priority: rst > flush > push/pop.

## Timing
- Latency from a push at edge N to out_valid = 1 is one cycle: it is visible after edge N.
- Throughput: one push and one pop per cycle in the steady state (0 < count < DEPTH).
- Handshake rules:
  - Fetch must hold in_valid, in_pc and in_instr stable until the transfer is accepted.
  - Decode may drop out_ready at any time.
  - The queue never drops out_valid without a pop, flush or rst.
- Flush asserted at edge N: out_valid = 0 and in_ready = 1 after edge N. The first post-redirect push is accepted at edge N+1 at the earliest.
- Reset in mid-operation follows the reset rules above: all entries are lost and outputs take their reset values one cycle later.

## Structure
- Shared package fetch_pkg holds:
  - the PC_W and INSTR_W defaults
  - the reset PC constant
  - a packed type fd_entry_t = {pc, instr}, reused by the decode-side register
- One sub-module, fd_queue_storage: a DEPTH x (PC_W+INSTR_W) register array with one write port and one asynchronous read port, plus a synchronous rst clear.
- Pointer, count, flush and handshake logic stay in fetch_decode_queue.

## Test plan
- Reset: hold rst for 2 cycles with in_valid = 1 → out_valid = 0, count = 0, in_ready = 1, out_pc = 0; no entry is accepted.
- Fill: out_ready = 0, push pc = 0x00, 0x04, 0x08, 0x0C → count goes 1, 2, 3, 4; in_ready = 0 after the 4th push; a 5th offer with pc = 0x10 is held off.
- Drain with wrap: from full, set out_ready = 1 and keep pushing 0x10, 0x14, … → outputs appear in order 0x00, 0x04, 0x08, 0x0C, 0x10; with pushing once in_ready returns, steady-state count stays at 3–4, pointers wrap past DEPTH-1, and no entry is lost or duplicated.
- Simultaneous push and pop: count = 2, push and pop in the same cycle → count stays 2 and the head advances by one.
- Flush: count = 3 with flush, in_valid and out_ready all high → next cycle count = 0 and out_valid = 0; a push of pc = 0x200 the cycle after appears as the head one cycle later.
- Empty boundary: count = 0, push with out_ready = 1 → no pop in that cycle; out_valid = 1 the next cycle with the pushed pc/instr.
